// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between an instruction fetch requester and a data requester.
// Data normally wins; a pending fetch is served once MAX_DSTREAK data completions have passed it.
module mem_arbiter #(
  parameter int MAX_DSTREAK = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ack,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  localparam int SW = (MAX_DSTREAK > 0) ? $clog2(MAX_DSTREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_e;

  state_e          state_q, state_d, curState;
  logic [SW-1:0]   dstreak_q, dstreak_d;
  logic            dReq;

  assign dReq = dREN | dWEN;

  // While reset is held the outputs already look like IDLE, so an abandoned grant never leaks to the RAM.
  assign curState = nRST ? state_q : IDLE;

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    iwait     = iREN;
    dwait     = dReq;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (curState)
      IDLE: begin
        if (dReq && !(iREN && (dstreak_q == STREAK_MAX))) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = 1'b1;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ack) begin
          iwait     = 1'b0;
          iload     = ramload;
          state_d   = IDLE;
          dstreak_d = '0;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
        dwait    = 1'b1;
        // A withdrawn request leaves without completing, so the streak is not touched.
        if (!dReq) begin
          state_d = IDLE;
        end else if (ram_ack) begin
          dwait   = 1'b0;
          state_d = IDLE;
          if (!dWEN) begin
            dload = ramload;
          end
          if (iREN) begin
            if (dstreak_q != STREAK_MAX) begin
              dstreak_d = dstreak_q + 1'b1;
            end
          end else begin
            dstreak_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a negedge monitor pops and compares them whenever a requester sees its wait drop.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] ramload = '0;
  logic        ram_ack = 1'b0;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;

  typedef struct {
    bit          isData;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] store;
    bit          chkLoad;
    logic [31:0] load;
  } exp_t;

  exp_t expQ[$];
  int   checksTotal = 0;
  int   checksPassed = 0;
  int   ackLat = 0;
  int   ackCnt = 0;
  logic [31:0] loadVal = 32'h0;

  mem_arbiter #(.MAX_DSTREAK(3)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ram_ack(ram_ack),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checksTotal++;
    if (act !== expv) begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] ds);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
  endtask

  task automatic pushI(input logic [31:0] a, input logic [31:0] ld);
    exp_t e;
    e.isData = 1'b0; e.addr = a; e.wen = 1'b0; e.store = '0; e.chkLoad = 1'b1; e.load = ld;
    expQ.push_back(e);
  endtask

  task automatic pushD(input logic [31:0] a, input bit w, input logic [31:0] s,
                       input bit chk, input logic [31:0] ld);
    exp_t e;
    e.isData = 1'b1; e.addr = a; e.wen = w; e.store = s; e.chkLoad = chk; e.load = ld;
    expQ.push_back(e);
  endtask

  // Waits (bounded) until at most n expectations remain, then lands 1 time unit after a rising edge.
  task automatic waitQueue(input int n, input int bound, input string name);
    int c = 0;
    while (expQ.size() > n && c < bound) begin
      @(posedge CLK);
      c++;
    end
    #1;
    checkOutput({name, " queue drained"}, expQ.size(), n);
  endtask

  // Simple RAM: acknowledges ackLat cycles after an enable first appears.
  always @(posedge CLK) begin
    #2;
    if (ramREN || ramWEN) begin
      ram_ack = (ackCnt == ackLat);
      ackCnt++;
    end else begin
      ram_ack = 1'b0;
      ackCnt  = 0;
    end
    ramload = ram_ack ? loadVal : 32'h5A5A5A5A;
  end

  logic iDone, dDone;
  exp_t mon;

  always @(negedge CLK) begin
    if (nRST) begin
      iDone = iREN && !iwait;
      dDone = (dREN || dWEN) && !dwait;
      if (iDone || dDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected completion", 32'd1, 32'd0);
        end else begin
          mon = expQ.pop_front();
          checkOutput("grant kind (1=data)", {31'b0, dDone}, {31'b0, mon.isData});
          checkOutput("ramaddr", ramaddr, mon.addr);
          if (mon.isData) begin
            checkOutput("ramWEN", {31'b0, ramWEN}, {31'b0, mon.wen});
            checkOutput("ramREN", {31'b0, ramREN}, {31'b0, !mon.wen});
            checkOutput("ramstore", ramstore, mon.store);
            if (mon.chkLoad) checkOutput("dload", dload, mon.load);
            checkOutput("iload during data ack", iload, 32'h0);
          end else begin
            checkOutput("ramREN", {31'b0, ramREN}, 32'd1);
            checkOutput("ramWEN", {31'b0, ramWEN}, 32'd0);
            checkOutput("iload", iload, mon.load);
            checkOutput("dload during instr ack", dload, 32'h0);
          end
        end
      end else begin
        checkOutput("iload outside ack", iload, 32'h0);
        checkOutput("dload outside ack", dload, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    // Reset behaviour with requests present
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 32'h55);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("reset ramREN", {31'b0, ramREN}, 32'd0);
    checkOutput("reset ramWEN", {31'b0, ramWEN}, 32'd0);
    checkOutput("reset ramaddr", ramaddr, 32'h0);
    checkOutput("reset ramstore", ramstore, 32'h0);
    checkOutput("reset iload", iload, 32'h0);
    checkOutput("reset dload", dload, 32'h0);
    checkOutput("reset iwait", {31'b0, iwait}, 32'd1);
    checkOutput("reset dwait", {31'b0, dwait}, 32'd1);
    @(posedge CLK); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nRST = 1'b1;

    // Single fetch, ack on the fourth grant cycle
    @(posedge CLK); #1;
    ackLat = 3; loadVal = 32'h8C010004;
    pushI(32'h40, 32'h8C010004);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("idle iwait", {31'b0, iwait}, 32'd1);
    checkOutput("idle ramREN", {31'b0, ramREN}, 32'd0);
    checkOutput("idle ramaddr", ramaddr, 32'h0);
    @(negedge CLK);
    checkOutput("igrant ramREN", {31'b0, ramREN}, 32'd1);
    checkOutput("igrant ramaddr", ramaddr, 32'h40);
    checkOutput("igrant iwait", {31'b0, iwait}, 32'd1);
    repeat (2) begin
      @(negedge CLK);
      checkOutput("iwait before ack", {31'b0, iwait}, 32'd1);
    end
    waitQueue(0, 3, "fetch");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fetch and write together: data first, then the fetch
    @(posedge CLK); #1;
    ackLat = 1; loadVal = 32'h11112222;
    pushD(32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    pushI(32'h40, 32'h11112222);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("dgrant ramWEN", {31'b0, ramWEN}, 32'd1);
    checkOutput("dgrant ramREN", {31'b0, ramREN}, 32'd0);
    checkOutput("dgrant ramstore", ramstore, 32'hDEADBEEF);
    checkOutput("dgrant ramaddr", ramaddr, 32'h100);
    checkOutput("dgrant iwait", {31'b0, iwait}, 32'd1);
    waitQueue(1, 4, "write before fetch");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("idle between grants ramREN", {31'b0, ramREN}, 32'd0);
    @(negedge CLK);
    checkOutput("fetch after write ramaddr", ramaddr, 32'h40);
    waitQueue(0, 4, "fetch after write");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // dREN and dWEN together: write wins
    @(posedge CLK); #1;
    ackLat = 0; loadVal = 32'h33334444;
    pushD(32'h180, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h180, 32'hCAFEF00D);
    waitQueue(0, 5, "read+write");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Both held: three data grants, then one fetch, repeated
    @(posedge CLK); #1;
    ackLat = 0; loadVal = 32'h0BADF00D;
    repeat (2) begin
      repeat (3) pushD(32'h200, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
      pushI(32'h40, 32'h0BADF00D);
    end
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200, 32'h77);
    waitQueue(0, 40, "streak order");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Data request withdrawn mid-grant, streak preserved at 1
    @(posedge CLK); #1;
    ackLat = 0;
    pushD(32'h300, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h77);
    waitQueue(0, 5, "streak setup");
    ackLat = 10;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("abort dgrant ramREN", {31'b0, ramREN}, 32'd1);
    checkOutput("abort dgrant dwait", {31'b0, dwait}, 32'd1);
    @(posedge CLK); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h300, 32'h77);
    @(negedge CLK);
    checkOutput("dwait held on abort", {31'b0, dwait}, 32'd1);
    @(negedge CLK);
    checkOutput("after abort ramREN", {31'b0, ramREN}, 32'd0);
    checkOutput("after abort ramWEN", {31'b0, ramWEN}, 32'd0);
    @(posedge CLK); #1;
    ackLat = 0;
    pushD(32'h300, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
    pushD(32'h300, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
    pushI(32'h40, 32'h0BADF00D);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 32'h77);
    waitQueue(0, 20, "streak after abort");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Saturate the streak, then reset during the fetch grant
    @(posedge CLK); #1;
    ackLat = 0;
    repeat (3) pushD(32'h400, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h400, 32'h77);
    waitQueue(0, 20, "saturate streak");
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    ackLat = 10;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("pre-reset igrant ramREN", {31'b0, ramREN}, 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(negedge CLK);
    checkOutput("mid-grant reset ramREN", {31'b0, ramREN}, 32'd0);
    checkOutput("mid-grant reset ramaddr", ramaddr, 32'h0);
    checkOutput("mid-grant reset iwait", {31'b0, iwait}, 32'd1);
    checkOutput("mid-grant reset iload", iload, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("post-reset idle ramREN", {31'b0, ramREN}, 32'd0);
    @(negedge CLK);
    checkOutput("igrant re-entered ramREN", {31'b0, ramREN}, 32'd1);
    checkOutput("igrant re-entered ramaddr", ramaddr, 32'h40);
    @(posedge CLK); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    checkOutput("iwait held on abort", {31'b0, iwait}, 32'd1);
    @(posedge CLK); #1;
    ackLat = 0;
    repeat (3) pushD(32'h500, 1'b0, 32'h77, 1'b1, 32'h0BADF00D);
    pushI(32'h40, 32'h0BADF00D);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h500, 32'h77);
    waitQueue(0, 30, "streak cleared by reset");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("leftover expectations", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_DSTREAK, default 3, consecutive data completions allowed while an instruction request waits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 nRST  in  1  synchronous active-low reset.
REQ-005 iREN  in  1  instruction fetch request.
REQ-006 iaddr  in  32  instruction address.
REQ-007 dREN  in  1  data read request.
REQ-008 dWEN  in  1  data write request.
REQ-009 daddr  in  32  data address.
REQ-010 dstore  in  32  data write value.
REQ-011 ramload  in  32  RAM read data, valid in the ram_ack cycle.
REQ-012 ram_ack  in  1  RAM completes the current access this cycle.
REQ-013 iwait  out  1  high = fetch not complete; low with iREN = iload valid this cycle.
REQ-014 dwait  out  1  high = data access not complete; low with dREN/dWEN = done this cycle.
REQ-015 iload, dload  out  32 each  RAM read data returned to the requester.
REQ-016 ramREN, ramWEN  out  1 each  RAM read/write enable.
REQ-017 ramaddr, ramstore  out  32 each  RAM address and write data.

Function
REQ-018 FSM states SHALL be IDLE, IGRANT and DGRANT, with a registered state and a registered streak counter dstreak of width clog2(MAX_DSTREAK+1).
REQ-019 In IDLE, all ram enables SHALL be 0, ramaddr/ramstore SHALL be 0, and iwait = iREN and dwait = (dREN|dWEN).
REQ-020 In IDLE, if (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK), next state SHALL be DGRANT.
REQ-021 In IDLE, otherwise if iREN, next state SHALL be IGRANT; if there is no request, state SHALL stay IDLE.
REQ-022 In IGRANT, the block SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr, and dwait=(dREN|dWEN).
REQ-023 In DGRANT, the block SHALL drive ramaddr=daddr and ramstore=dstore, and iwait=iREN.
REQ-024 In DGRANT, dWEN=1 SHALL give ramWEN=1, ramREN=0; otherwise ramREN=1, ramWEN=0 (dWEN wins if both are high).
REQ-025 In a grant state, the granted wait SHALL be high until the ram_ack cycle, then low combinationally in that cycle, with iload/dload=ramload for reads.
REQ-026 iload and dload SHALL be 0 outside their ack cycle.
REQ-027 After ram_ack, next state SHALL be IDLE; back-to-back requests SHALL be granted no earlier than the cycle after IDLE is entered (minimum two cycles per access).
REQ-028 If the granted request deasserts before ram_ack, next state SHALL be IDLE, the wait SHALL stay high, dstreak SHALL be unchanged, and RAM enables SHALL be 0 from the next cycle.
REQ-029 If the granted address or direction changes mid-grant, the outputs SHALL follow the inputs combinationally; requesters must hold them stable.
REQ-030 On each data completion (DGRANT and ram_ack) with iREN high, dstreak SHALL increment, saturating at MAX_DSTREAK.
REQ-031 On each data completion with iREN low, dstreak SHALL clear to 0.
REQ-032 On instruction completion, dstreak SHALL clear to 0.
REQ-033 ram_ack in IDLE SHALL be ignored.
REQ-034 Latency SHALL be one IDLE cycle plus the RAM cycles to ack; ram_ack in the first grant cycle gives a 2-cycle access.

Reset
REQ-035 When nRST=0 at a rising edge, the block SHALL set state=IDLE and dstreak=0, including mid-grant; the outstanding access is abandoned without a wait-low pulse.
REQ-036 During and after reset, outputs SHALL be: ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, iwait=iREN, dwait=(dREN|dWEN).

Verification
REQ-037 iREN=1, iaddr=0x40, ack 3 cycles after grant -> ramREN=1, ramaddr=0x40 in IGRANT; iwait low in the ack cycle only, iload=ramload=0x8C010004.
REQ-038 iREN and dWEN high together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; after ack -> IDLE then IGRANT.
REQ-039 iREN held, dREN held, MAX_DSTREAK=3, ack each first grant cycle -> grant order D,D,D,I,D,D,D,I; dstreak reaches 3 then clears.
REQ-040 dREN and dWEN both high -> ramWEN=1, ramREN=0.
REQ-041 dREN drops mid-DGRANT before ack -> IDLE next cycle, no dwait-low pulse, dstreak unchanged.
REQ-042 nRST=0 during IGRANT -> next edge IDLE, ramREN=0, dstreak=0; with iREN still high, IGRANT is re-entered one cycle after nRST=1.
